// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// uart_tx_fifo : 8N1/8N2 LSB-first UART transmitter fed by a small byte FIFO
// Revision 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_PER_HALF_BIT = 5208,
    parameter int FIFO_DEPTH       = 4,
    parameter int STOP_BITS        = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [7:0]                    tdata,
    input  logic                          tvalid,
    output logic                          tready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int T  = 2 * CLK_PER_HALF_BIT;
    localparam int TW = $clog2(T);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      idx_q,   idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q,   txd_d;
    logic [AW-1:0]   wptr_q,  wptr_d;
    logic [AW-1:0]   rptr_q,  rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem [FIFO_DEPTH];

    logic            push;
    logic            pop;
    logic            last_tick;
    logic            fifo_nonempty;

    // tready is gated by rstn so no push can be accepted while reset is held
    assign tready        = rstn & (count_q != CW'(FIFO_DEPTH));
    assign push          = tvalid & tready;
    assign fifo_nonempty = (count_q != '0);
    assign last_tick     = (timer_q == TW'(T - 1));

    always_comb begin
        state_d = state_q;
        timer_d = last_tick ? '0 : timer_q + TW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem[rptr_q];
                    txd_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (last_tick) begin
                    state_d = S_DATA;
                    idx_d   = 3'd0;
                    txd_d   = shift_q[0];
                end
            end
            S_DATA: begin
                if (last_tick) begin
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                        idx_d   = 3'd0;
                        txd_d   = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end
            end
            S_STOP: begin
                if (last_tick) begin
                    if (idx_q == 3'(STOP_BITS - 1)) begin
                        // Chain straight into the next start bit when a byte is waiting
                        if (fifo_nonempty) begin
                            pop     = 1'b1;
                            shift_d = mem[rptr_q];
                            txd_d   = 1'b0;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_comb begin
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= tdata;
        end
    end

    assign txd        = txd_q;
    assign busy       = (state_q != S_IDLE) | fifo_nonempty;
    assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_uart_tx_fifo : directed bench for uart_tx_fifo (T=8, depth 4, 1 and 2 stop bits)
// Revision 1.0
// ============================================================================
module tb_uart_tx_fifo;

    logic       clk    = 1'b0;
    logic       rstn   = 1'b1;
    logic [7:0] tdata  = 8'h00;
    logic       tvalid = 1'b0;
    logic [7:0] tdata2 = 8'h00;
    logic       tvalid2 = 1'b0;
    logic       tready, txd, busy;
    logic       tready2, txd2, busy2;
    logic [2:0] fifo_count, fifo_count2;

    int tests  = 0;
    int fails  = 0;
    int cyc    = 0;
    int rx_err = 0;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(.CLK_PER_HALF_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
        .clk(clk), .rstn(rstn), .tdata(tdata), .tvalid(tvalid), .tready(tready),
        .txd(txd), .busy(busy), .fifo_count(fifo_count)
    );

    uart_tx_fifo #(.CLK_PER_HALF_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
        .clk(clk), .rstn(rstn), .tdata(tdata2), .tvalid(tvalid2), .tready(tready2),
        .txd(txd2), .busy(busy2), .fifo_count(fifo_count2)
    );

    // Mid-bit sampling receiver for the 1-stop-bit instance; frames hit by reset are dropped
    initial begin : rx_model
        logic [7:0] d;
        logic       ab;
        forever begin
            @(posedge clk); #2;
            if (rstn === 1'b1 && txd === 1'b0) begin
                ab = 1'b0;
                d  = 8'h00;
                for (int c = 1; c <= 75; c++) begin
                    @(posedge clk); #2;
                    if (rstn !== 1'b1) ab = 1'b1;
                    if (c == 3 && txd !== 1'b0) ab = 1'b1;
                    if (c >= 11 && c <= 67 && ((c - 11) % 8) == 0) d[(c - 11) / 8] = txd;
                    if (c == 75 && txd !== 1'b1) ab = 1'b1;
                end
                if (!ab) rx_q.push_back(d);
                else     rx_err++;
            end
        end
    end

    function automatic logic frame_bit(input logic [7:0] d, input int c);
        int k;
        k = c / 8;
        if (k == 0)      return 1'b0;
        else if (k <= 8) return d[k - 1];
        else             return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 2000 && busy !== 1'b0; n++) tick();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) tick();
        tests++; if (txd !== 1'b1)         begin fails++; $display("FAIL reset_txd: got %b exp 1", txd); end
        tests++; if (busy !== 1'b0)        begin fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
        tests++; if (fifo_count !== 3'd0)  begin fails++; $display("FAIL reset_count: got %0d exp 0", fifo_count); end
        tests++; if (tready !== 1'b0)      begin fails++; $display("FAIL reset_tready: got %b exp 0", tready); end
        tests++; if (txd2 !== 1'b1 || busy2 !== 1'b0) begin fails++; $display("FAIL reset_dut2: txd2 %b busy2 %b exp 1 0", txd2, busy2); end
        @(posedge clk); #3 rstn = 1'b1; #1;
        tests++; if (tready !== 1'b1)      begin fails++; $display("FAIL release_tready: got %b exp 1", tready); end
        tick();
    endtask

    task automatic test_single();
        rx_q.delete();
        tdata = 8'h55; tvalid = 1'b1;
        tick();
        tvalid = 1'b0;
        tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL single_count: got %0d exp 1", fifo_count); end
        tests++; if (txd !== 1'b1)        begin fails++; $display("FAIL single_latency: txd got %b exp 1", txd); end
        for (int c = 0; c < 80; c++) begin
            tick();
            tests++;
            if (txd !== frame_bit(8'h55, c)) begin
                fails++; $display("FAIL single_txd c=%0d: got %b exp %b", c, txd, frame_bit(8'h55, c));
            end
        end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_last: got %b exp 1", busy); end
        tick();
        tests++; if (busy !== 1'b0 || txd !== 1'b1) begin fails++; $display("FAIL single_end: busy %b txd %b exp 0 1", busy, txd); end
        wait_idle();
        tests++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
            fails++; $display("FAIL single_rx: got %0d bytes first %h exp 1 byte 55", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        rx_q.delete();
        tdata = 8'hA5; tvalid = 1'b1;
        tick();
        tdata = 8'h3C;
        tick();
        tvalid = 1'b0;
        tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL b2b_count: got %0d exp 1", fifo_count); end
        for (int c = 0; c < 160; c++) begin
            if (c != 0) tick();
            b = (c < 80) ? 8'hA5 : 8'h3C;
            tests++;
            if (txd !== frame_bit(b, c % 80)) begin
                fails++; $display("FAIL b2b_txd c=%0d: got %b exp %b", c, txd, frame_bit(b, c % 80));
            end
        end
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_end: got %b exp 0", busy); end
        wait_idle();
        tests++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h3C) begin
            fails++; $display("FAIL b2b_rx: got %0d bytes exp A5 3C", rx_q.size());
        end
    endtask

    task automatic test_full();
        int c0;
        int n;
        rx_q.delete();
        for (int i = 1; i <= 5; i++) begin
            tdata = 8'(i); tvalid = 1'b1;
            tick();
        end
        c0 = cyc - 4;
        tdata = 8'h06;
        tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL full_count: got %0d exp 4", fifo_count); end
        tests++; if (tready !== 1'b0)     begin fails++; $display("FAIL full_tready: got %b exp 0", tready); end
        n = 0;
        while (tready !== 1'b1 && n < 200) begin tick(); n++; end
        tests++; if (cyc - c0 != 81) begin fails++; $display("FAIL full_tready_rise: got cycle %0d exp 81", cyc - c0); end
        tick();
        tvalid = 1'b0;
        tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL full_accept6: count got %0d exp 4", fifo_count); end
        wait_idle();
        tests++;
        if (rx_q.size() != 6) begin
            fails++; $display("FAIL full_rx_len: got %0d exp 6", rx_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests++;
                if (rx_q[i] !== 8'(i + 1)) begin fails++; $display("FAIL full_rx[%0d]: got %h exp %h", i, rx_q[i], 8'(i + 1)); end
            end
        end
    endtask

    task automatic test_same_edge();
        rx_q.delete();
        tdata = 8'h12; tvalid = 1'b1;
        tick();
        tdata = 8'h34;
        tick();
        tvalid = 1'b0;
        repeat (79) tick();
        tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL same_pre_count: got %0d exp 1", fifo_count); end
        tdata = 8'h56; tvalid = 1'b1;
        tick();
        tvalid = 1'b0;
        tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL same_post_count: got %0d exp 1", fifo_count); end
        tests++; if (txd !== 1'b0)        begin fails++; $display("FAIL same_start: txd got %b exp 0", txd); end
        wait_idle();
        tests++;
        if (rx_q.size() != 3 || rx_q[0] !== 8'h12 || rx_q[1] !== 8'h34 || rx_q[2] !== 8'h56) begin
            fails++; $display("FAIL same_rx: got %0d bytes exp 12 34 56", rx_q.size());
        end
    endtask

    task automatic test_reset_mid();
        rx_q.delete();
        tdata = 8'hF0; tvalid = 1'b1;
        tick();
        tdata = 8'h11;
        tick();
        tdata = 8'h22;
        tick();
        tvalid = 1'b0;
        tests++; if (fifo_count !== 3'd2) begin fails++; $display("FAIL rmid_queued: got %0d exp 2", fifo_count); end
        repeat (34) tick();
        tests++; if (txd !== 1'b0) begin fails++; $display("FAIL rmid_bit3: txd got %b exp 0", txd); end
        #3 rstn = 1'b0;
        #1;
        tests++; if (txd !== 1'b1)        begin fails++; $display("FAIL rmid_txd: got %b exp 1", txd); end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL rmid_count: got %0d exp 0", fifo_count); end
        tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL rmid_busy: got %b exp 0", busy); end
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            tests++;
            if (txd !== 1'b1 || busy !== 1'b0) begin
                fails++; $display("FAIL rmid_idle c=%0d: txd %b busy %b exp 1 0", c, txd, busy);
            end
        end
        tests++; if (rx_q.size() != 0) begin fails++; $display("FAIL rmid_no_rx: got %0d bytes exp 0", rx_q.size()); end
        tdata = 8'h81; tvalid = 1'b1;
        tick();
        tvalid = 1'b0;
        wait_idle();
        tests++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h81) begin
            fails++; $display("FAIL rmid_resume_rx: got %0d bytes exp 1 byte 81", rx_q.size());
        end
    endtask

    task automatic test_stop2();
        logic e;
        tdata2 = 8'h00; tvalid2 = 1'b1;
        tick();
        tick();
        tvalid2 = 1'b0;
        for (int c = 0; c < 176; c++) begin
            if (c != 0) tick();
            e = ((c % 88) < 72) ? 1'b0 : 1'b1;
            tests++;
            if (txd2 !== e) begin fails++; $display("FAIL stop2_txd c=%0d: got %b exp %b", c, txd2, e); end
        end
        tick();
        tests++; if (busy2 !== 1'b0 || txd2 !== 1'b1) begin fails++; $display("FAIL stop2_end: busy2 %b txd2 %b exp 0 1", busy2, txd2); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_same_edge();
        test_reset_mid();
        test_stop2();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
